// File: rtl/instruction_prefetch_pkg.sv
// ============================================================================
// Module      : instruction_prefetch_pkg
// Description : Shared fetch-pipeline widths and prefetch FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_prefetch_pkg;

    localparam int unsigned PF_PC_WIDTH = 32;
    localparam int unsigned PF_IWIDTH   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } pf_state_e;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int unsigned pf_count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_prefetch_fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Power-of-two circular queue of {pc, instruction} entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import instruction_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 64
) (
    input  logic                           f_clk,
    input  logic                           f_rst,
    input  logic                           i_flush,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [DW-1:0]                  i_data,
    output logic [DW-1:0]                  o_data,
    output logic [pf_count_width(DEPTH)-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = pf_count_width(DEPTH);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_pop    = i_pop && (count_q != '0);
        w_push   = i_push && ((count_q != C_FULL) || w_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) wide, so wrap is free.
            if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge f_clk) begin
        if (w_push && !i_flush) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/instruction_prefetch.sv
// ============================================================================
// Module      : instruction_prefetch
// Description : Single-outstanding instruction prefetcher with redirect/drop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_prefetch
    import instruction_prefetch_pkg::*;
#(
    parameter int unsigned         PC_WIDTH = PF_PC_WIDTH,
    parameter int unsigned         IWIDTH   = PF_IWIDTH,
    parameter int unsigned         DEPTH    = 4,
    parameter int unsigned         PC_STEP  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                    f_clk,
    input  logic                    f_rst,
    input  logic                    f_i_ce,
    input  logic                    f_i_stall,
    input  logic                    f_i_change_pc,
    input  logic [PC_WIDTH-1:0]     f_i_pc,
    output logic                    f_o_syn,
    output logic [PC_WIDTH-1:0]     f_o_req_pc,
    input  logic [IWIDTH-1:0]       f_i_instr,
    input  logic                    f_i_ack,
    input  logic                    f_i_last,
    output logic [IWIDTH-1:0]       f_o_instr,
    output logic [PC_WIDTH-1:0]     f_o_pc,
    output logic                    f_o_ce,
    output logic [$clog2(DEPTH):0]  f_o_count
);

    localparam int unsigned CNT_W = pf_count_width(DEPTH);
    localparam int unsigned QW    = PC_WIDTH + IWIDTH;
    localparam logic [CNT_W:0]       C_DEPTH = (CNT_W + 1)'(DEPTH);
    localparam logic [PC_WIDTH-1:0]  C_STEP  = PC_WIDTH'(PC_STEP);

    pf_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                drop_q, drop_d;
    logic                rsp_v_q, rsp_v_d;
    logic [QW-1:0]       rsp_q, rsp_d;

    logic [CNT_W-1:0]    w_count;
    logic [QW-1:0]       w_head;
    logic [CNT_W:0]      w_occ;
    logic                w_redirect;
    logic                w_flush;
    logic                w_pop;
    logic                w_credit;
    logic                w_syn;
    logic                w_outstanding;

    always_comb begin
        w_redirect    = f_i_ce & f_i_change_pc;
        w_flush       = ~f_i_ce | w_redirect;
        w_pop         = (w_count != '0) & ~f_i_stall;
        // The staged response already owns a queue slot.
        w_occ         = {1'b0, w_count} + {{CNT_W{1'b0}}, rsp_v_q} - {{CNT_W{1'b0}}, w_pop};
        w_credit      = w_occ < C_DEPTH;
        w_syn         = (state_q == ST_FETCH) & ~drop_q & ~w_flush & w_credit;
        w_outstanding = (state_q == ST_WAIT) | drop_q;
    end

    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        rsp_v_d  = 1'b0;
        rsp_d    = rsp_q;
        if (!f_i_ce) begin
            state_d  = ST_IDLE;
            req_pc_d = RESET_PC;
            drop_d   = 1'b0;
        end else if (w_redirect) begin
            state_d  = ST_FETCH;
            req_pc_d = f_i_pc;
            // A same-cycle ack retires the old request, so nothing is left to drop.
            drop_d   = w_outstanding & ~f_i_ack;
        end else begin
            if (drop_q && f_i_ack) drop_d = 1'b0;
            case (state_q)
                ST_IDLE:  state_d = ST_FETCH;
                ST_FETCH: if (w_syn) state_d = ST_WAIT;
                ST_WAIT: begin
                    if (f_i_ack) begin
                        rsp_v_d  = 1'b1;
                        rsp_d    = {req_pc_q, f_i_instr};
                        req_pc_d = req_pc_q + C_STEP;
                        state_d  = f_i_last ? ST_DONE : ST_FETCH;
                    end
                end
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            state_q  <= ST_IDLE;
            req_pc_q <= RESET_PC;
            drop_q   <= 1'b0;
            rsp_v_q  <= 1'b0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            rsp_v_q  <= rsp_v_d;
            rsp_q    <= rsp_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .DW    (QW)
    ) u_queue (
        .f_clk   (f_clk),
        .f_rst   (f_rst),
        .i_flush (w_flush),
        .i_push  (rsp_v_q),
        .i_pop   (w_pop),
        .i_data  (rsp_q),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign f_o_syn             = w_syn;
    assign f_o_req_pc          = req_pc_q;
    assign f_o_count           = w_count;
    assign f_o_ce              = (w_count != '0);
    assign {f_o_pc, f_o_instr} = w_head;

endmodule

`default_nettype wire

// File: tb/tb_instruction_prefetch.sv
// ============================================================================
// Module      : tb_instruction_prefetch
// Description : Randomized bench for instruction_prefetch with queue-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_prefetch;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        f_clk = 1'b0;
    logic        f_rst = 1'b1;
    logic        f_i_ce, f_i_stall, f_i_change_pc, f_i_ack, f_i_last;
    logic [31:0] f_i_pc, f_i_instr;
    logic        f_o_syn, f_o_ce;
    logic [31:0] f_o_req_pc, f_o_instr, f_o_pc;
    logic [2:0]  f_o_count;

    instruction_prefetch #(
        .PC_WIDTH (32),
        .IWIDTH   (32),
        .DEPTH    (DEPTH),
        .PC_STEP  (4),
        .RESET_PC (32'h0)
    ) dut (
        .f_clk         (f_clk),
        .f_rst         (f_rst),
        .f_i_ce        (f_i_ce),
        .f_i_stall     (f_i_stall),
        .f_i_change_pc (f_i_change_pc),
        .f_i_pc        (f_i_pc),
        .f_o_syn       (f_o_syn),
        .f_o_req_pc    (f_o_req_pc),
        .f_i_instr     (f_i_instr),
        .f_i_ack       (f_i_ack),
        .f_i_last      (f_i_last),
        .f_o_instr     (f_o_instr),
        .f_o_pc        (f_o_pc),
        .f_o_ce        (f_o_ce),
        .f_o_count     (f_o_count)
    );

    always #5 f_clk = ~f_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int first_ack = -1;
    int first_ce  = -1;
    logic [31:0] pops[$];

    // Reference model: visible queue, one staged response, fetch bookkeeping.
    ent_t        m_q[$];
    ent_t        m_stage;
    bit          m_stage_v, m_idle, m_busy, m_drop, m_done;
    logic [31:0] m_pc;
    bit          exp_syn, exp_pop;

    // Memory responder.
    bit          mem_busy, syn_seen;
    logic [31:0] mem_addr, req_seen;
    int          mem_cnt, mem_dmax, last_pct;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_stage_v = 1'b0;
        m_pc      = 32'h0;
        m_idle    = 1'b1;
        m_busy    = 1'b0;
        m_drop    = 1'b0;
        m_done    = 1'b0;
    endtask

    task automatic model_step();
        if (!f_i_ce) begin
            model_reset();
        end else if (f_i_change_pc) begin
            m_drop = (m_busy || m_drop) && !f_i_ack;
            m_q.delete();
            m_stage_v = 1'b0;
            m_pc   = f_i_pc;
            m_idle = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            if (exp_pop) void'(m_q.pop_front());
            if (m_stage_v) m_q.push_back(m_stage);
            m_stage_v = 1'b0;
            if (m_idle) begin
                m_idle = 1'b0;
            end else if (m_drop) begin
                if (f_i_ack) m_drop = 1'b0;
            end else if (m_busy) begin
                if (f_i_ack) begin
                    m_stage.pc  = m_pc;
                    m_stage.ins = f_i_instr;
                    m_stage_v   = 1'b1;
                    m_pc        = m_pc + 32'd4;
                    m_busy      = 1'b0;
                    m_done      = f_i_last;
                end
            end else if (exp_syn) begin
                m_busy = 1'b1;
            end
        end
    endtask

    task automatic mem_step();
        if (!f_i_ce || f_i_ack) mem_busy = 1'b0;
        if (syn_seen && f_i_ce) begin
            mem_busy = 1'b1;
            mem_addr = req_seen;
            mem_cnt  = int'($urandom_range(0, mem_dmax));
        end
    endtask

    task automatic mem_drive();
        f_i_ack   = 1'b0;
        f_i_last  = 1'b0;
        f_i_instr = $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                f_i_ack   = 1'b1;
                f_i_instr = mem_word(mem_addr);
                f_i_last  = ($urandom_range(0, 99) < last_pct);
                if (first_ack < 0) first_ack = cyc;
            end else begin
                mem_cnt--;
            end
        end
    endtask

    task automatic cycle();
        ent_t h;
        @(negedge f_clk);
        exp_pop = (m_q.size() != 0) && !f_i_stall;
        exp_syn = f_i_ce && !f_i_change_pc && !m_idle && !m_busy && !m_drop && !m_done
                  && ((m_q.size() + int'(m_stage_v) - int'(exp_pop)) < DEPTH);
        h = '0;
        if (m_q.size() != 0) h = m_q[0];
        chk("syn", 64'(f_o_syn), 64'(exp_syn));
        if (exp_syn) chk("req_pc", 64'(f_o_req_pc), 64'(m_pc));
        chk("count", 64'(f_o_count), 64'(m_q.size()));
        chk("ce", 64'(f_o_ce), 64'(m_q.size() != 0));
        chk("pc", 64'(f_o_pc), 64'(h.pc));
        chk("instr", 64'(f_o_instr), 64'(h.ins));
        if (f_o_ce && first_ce < 0) first_ce = cyc;
        if (exp_pop && pops.size() < 8) pops.push_back(h.pc);
        syn_seen = f_o_syn;
        req_seen = f_o_req_pc;
        @(posedge f_clk);
        model_step();
        mem_step();
        cyc++;
        #1;
        mem_drive();
    endtask

    task automatic drive_ctrl(input int stall_pct, input int redir_pct, input int celow_pct);
        f_i_stall     = ($urandom_range(0, 99) < stall_pct);
        f_i_change_pc = ($urandom_range(0, 99) < redir_pct);
        f_i_pc        = 32'($urandom_range(0, 63)) << 2;
        f_i_ce        = !($urandom_range(0, 99) < celow_pct);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_syn"},   64'(f_o_syn),   64'(0));
        chk({tag, "_ce"},    64'(f_o_ce),    64'(0));
        chk({tag, "_count"}, 64'(f_o_count), 64'(0));
        chk({tag, "_pc"},    64'(f_o_pc),    64'(0));
        chk({tag, "_instr"}, 64'(f_o_instr), 64'(0));
    endtask

    initial begin
        bit found;
        f_i_ce = 1'b1; f_i_stall = 1'b0; f_i_change_pc = 1'b0; f_i_pc = '0;
        f_i_instr = '0; f_i_ack = 1'b0; f_i_last = 1'b0;
        mem_busy = 1'b0; syn_seen = 1'b0; mem_dmax = 0; last_pct = 0;
        model_reset();

        #1 f_rst = 1'b0;
        #2 check_zero_outputs("rst");
        #5 f_rst = 1'b1;

        // Single-cycle memory, no stall: sequential PCs and first-visible latency.
        repeat (16) cycle();
        chk("p1_npops", 64'(pops.size() >= 4), 64'(1));
        for (int i = 0; i < 4; i++)
            chk("p1_pop_pc", (i < pops.size()) ? 64'(pops[i]) : 64'hFFFF, 64'(i * 4));
        chk("p1_ce_latency", 64'(first_ce - first_ack), 64'(2));

        // Held stall fills the queue exactly to DEPTH, then drains one per cycle.
        mem_dmax  = 2;
        f_i_stall = 1'b1;
        repeat (30) cycle();
        chk("p2_full_count", 64'(f_o_count), 64'(4));
        chk("p2_full_syn", 64'(f_o_syn), 64'(0));
        f_i_stall = 1'b0;
        cycle();
        chk("p2_drain1", 64'(f_o_count), 64'(3));
        cycle();
        chk("p2_drain2", 64'(f_o_count), 64'(2));

        // Random traffic: stalls, redirects, enable drops, last words.
        mem_dmax = 3;
        last_pct = 5;
        repeat (2500) begin
            drive_ctrl(30, 6, 2);
            cycle();
        end

        // Async reset while a request is outstanding with two entries queued.
        last_pct = 0;
        f_i_ce = 1'b1; f_i_stall = 1'b1;
        f_i_change_pc = 1'b1; f_i_pc = 32'h40;
        cycle();
        f_i_change_pc = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle();
            if (m_busy && m_q.size() >= 2) found = 1'b1;
        end
        chk("p4_setup", 64'(found), 64'(1));
        #1 f_rst = 1'b0;
        #1 check_zero_outputs("async_rst");
        #1 f_rst = 1'b1;
        model_reset();
        mem_busy  = 1'b0;
        f_i_stall = 1'b0;
        f_i_ack   = 1'b1;
        f_i_instr = $urandom;
        repeat (10) cycle();
        repeat (400) begin
            drive_ctrl(25, 5, 1);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
